// File: rtl/train_pkg.sv
// Shared definitions for the track-sensor conditioner: debounce state encodings,
// default timing parameters and sensor bit positions.
package train_pkg;

    typedef enum logic [3:0] {
        LOW       = 4'b0001,
        RISE_WAIT = 4'b0010,
        HIGH      = 4'b0100,
        FALL_WAIT = 4'b1000
    } deb_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int STUCK_CYCLES_DEF    = 65535;
    localparam int CNT_W_DEF           = 16;

    localparam int SEN_S1 = 0;
    localparam int SEN_S2 = 1;
    localparam int SEN_S3 = 2;
    localparam int SEN_S4 = 3;
    localparam int NUM_SEN = 4;

endpackage : train_pkg

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-flop synchronizer, debounce FSM with shared counter,
// registered level and rise pulse, and a sticky stuck-high fault bit.
module sensor_debounce
    import train_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    input  logic fault_clr_i,
    output logic level_o,
    output logic rise_o,
    output logic fault_o
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STUCK_MAX = CNT_W'(STUCK_CYCLES);
    localparam logic [CNT_W-1:0] STUCK_PRE = CNT_W'(STUCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             sync1_q;
    logic             sync_q;
    deb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync_q  <= sync1_q;
        end
    end

    // Fault clear is applied first so that a set in the same cycle overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            if (fault_clr_i) begin
                fault_q <= 1'b0;
            end
            case (state_q)
                LOW: begin
                    level_q <= 1'b0;
                    if (sync_q) begin
                        state_q <= RISE_WAIT;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                RISE_WAIT: begin
                    if (!sync_q) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HIGH: begin
                    level_q <= 1'b1;
                    if (!sync_q) begin
                        state_q <= FALL_WAIT;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        if (cnt_q != STUCK_MAX) begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                        if (cnt_q >= STUCK_PRE) begin
                            fault_q <= 1'b1;
                        end
                    end
                end
                FALL_WAIT: begin
                    if (sync_q) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                    end else if (cnt_q == DB_LAST) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= LOW;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fault_o = fault_q;

endmodule : sensor_debounce

// File: rtl/train_sensor_conditioner.sv
// Four independent debounced track-sensor channels feeding the train controller,
// plus a registered summary of all stuck-sensor faults.
module train_sensor_conditioner
    import train_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SEN-1:0]   S_raw,
    input  logic                 fault_clr,
    output logic                 S1,
    output logic                 S2,
    output logic                 S3,
    output logic                 S4,
    output logic [NUM_SEN-1:0]   S_rise,
    output logic [NUM_SEN-1:0]   fault,
    output logic                 any_fault
);

    logic [NUM_SEN-1:0] level;
    logic               any_fault_q;

    for (genvar ch = 0; ch < NUM_SEN; ch++) begin : g_ch
        sensor_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .STUCK_CYCLES    (STUCK_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk         (clk),
            .rst_n       (rst_n),
            .raw_i       (S_raw[ch]),
            .fault_clr_i (fault_clr),
            .level_o     (level[ch]),
            .rise_o      (S_rise[ch]),
            .fault_o     (fault[ch])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_fault_q <= 1'b0;
        end else begin
            any_fault_q <= |fault;
        end
    end

    assign S1        = level[SEN_S1];
    assign S2        = level[SEN_S2];
    assign S3        = level[SEN_S3];
    assign S4        = level[SEN_S4];
    assign any_fault = any_fault_q;

endmodule : train_sensor_conditioner

// File: doc/train_sensor_conditioner.md
# train_sensor_conditioner

Front-end stage that sits directly upstream of the train controller. It takes the four raw, asynchronous, bouncy track-sensor contacts and turns them into the clean, synchronous level signals S1..S4 that the controller samples. It also produces one-cycle rising-edge pulses and a sticky stuck-sensor fault flag per channel. It adds a fixed, known latency and rejects glitches shorter than the debounce window.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive synchronized samples required to accept a level change (legal range ≥2).
- STUCK_CYCLES, 65535, consecutive cycles in debounced-high before a channel is flagged stuck (legal range > DEBOUNCE_CYCLES).
- CNT_W, 16, counter width; must hold STUCK_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- S_raw  in  4  raw sensor contacts, bit0=S1 … bit3=S4; asynchronous to clk.
- fault_clr  in  1  synchronous clear of all fault bits; level, sampled each cycle.
- S1, S2, S3, S4  out  1 each  debounced sensor levels, registered; drive the controller directly.
- S_rise  out  4  one-cycle pulse on each debounced 0→1 transition.
- fault  out  4  sticky per-channel stuck-high flag.
- any_fault  out  1  OR of fault, registered.

## Operation

- Each channel is independent and identical.
- Each channel has a 2-flop synchronizer, then a debounce FSM with a counter cnt[CNT_W-1:0].
- FSM states, one-hot: LOW, RISE_WAIT, HIGH, FALL_WAIT. Only sync (the synchronizer output) drives transitions.
- LOW: out=0. If sync=1, go to RISE_WAIT with cnt=1.
- RISE_WAIT: out=0.
  - If sync=0, go to LOW with cnt=0.
  - Else if cnt==DEBOUNCE_CYCLES-1, go to HIGH, set out=1, pulse S_rise for one cycle, and set cnt=0.
  - Else cnt+1.
- HIGH: out=1.
  - If sync=0, go to FALL_WAIT with cnt=1.
  - Else cnt saturates at STUCK_CYCLES.
  - When cnt reaches STUCK_CYCLES, fault is set.
- FALL_WAIT: out=1.
  - If sync=1, return to HIGH with cnt=0. The stuck count restarts; a bounce is not evidence of a stuck sensor.
  - Else if cnt==DEBOUNCE_CYCLES-1, go to LOW, set out=0, cnt=0.
  - Else cnt+1.
- Fault bits:
  - Set only from HIGH.
  - Cleared only by reset or fault_clr.
  - If fault_clr and a set condition occur in the same cycle, set wins.
  - A fault never alters S1..S4.
- Illegal or non-one-hot state recovers to LOW with out=0 and cnt=0 on the next edge.

## Timing

- Reset (rst_n=0, asynchronous):
  - Synchronizers = 0, all FSMs = LOW, cnt = 0.
  - S1..S4 = 0, S_rise = 0, fault = 0, any_fault = 0.
- Reset mid-debounce discards all progress. Outputs go to 0 immediately, without waiting for a clock.
- Rise latency: with S_raw held high, Sn asserts on the (DEBOUNCE_CYCLES+2)th rising edge counting the first edge that samples it high. S_rise pulses on that same edge and deasserts on the next.
- Fall latency is the same, DEBOUNCE_CYCLES+2 edges.
- A raw pulse or gap lasting fewer than DEBOUNCE_CYCLES synchronized samples produces no output change.
- any_fault lags fault by one cycle.
- Channels never interact. Simultaneous changes on several inputs give simultaneous, independent outputs.

## Structure

- Package train_pkg holds:
  - the one-hot state encodings (LOW, RISE_WAIT, HIGH, FALL_WAIT);
  - default values for DEBOUNCE_CYCLES and STUCK_CYCLES;
  - the sensor bit indices SEN_S1..SEN_S4.
- Sub-module sensor_debounce contains the synchronizer, FSM, counter and fault bit for one channel. The top instantiates it four times and registers any_fault.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4 and STUCK_CYCLES=20.

- Clean edge: S_raw[0] rises and is held → S1=1 and S_rise[0]=1 on the 6th edge; S_rise[0]=0 on the 7th. Falling edge → S1=0 six edges after the fall.
- Glitch rejection: 3-cycle high pulse on S_raw[1] → S2 stays 0 and S_rise stays 0. A 3-cycle low gap while S2=1 → S2 stays 1 and no new S_rise.
- Stuck sensor: S_raw[2] held high → fault[2]=1 twenty edges after S3 rises, any_fault one edge later. S3 stays 1. fault_clr with the input still high → fault is re-set on the next edge.
- Simultaneous edges: all four raw inputs rise on the same edge → S1..S4 and all S_rise bits assert on the same (6th) edge.
- Reset mid-operation: assert rst_n low in RISE_WAIT and in HIGH → outputs go to 0 immediately. After release with the input still high, the output needs a full 6 edges again.
- Bounce inside FALL_WAIT: while S4=1, drop for 2 cycles then return high → S4 stays 1, the stuck count restarts, and fault timing shifts accordingly.
